// File: rtl/fifo_ms_pkg.sv
// fifo_ms_pkg: shared arbiter state, channel count and counter width
// for the dual-channel FIFO drain arbiter.
package fifo_ms_pkg;

  localparam int NCH   = 2;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fifo_ms_skid2.sv
// fifo_ms_skid2: 2-entry tagged output buffer, head at entry 0.
// Accepts a push and a pop in the same cycle even when full.
module fifo_ms_skid2 #(
  parameter int DW = 8
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_ch,
  input  logic          pop_ready,
  output logic [DW-1:0] head_data,
  output logic          head_ch,
  output logic          head_valid,
  output logic [1:0]    occ
);

  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic          c0_q, c0_d, c1_q, c1_d;
  logic [1:0]    cnt_q, cnt_d, cnt_pop;
  logic          valid_q, valid_d;
  logic          pop;

  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    pop     = valid_q & pop_ready;
    cnt_pop = cnt_q - 2'(pop);
    if (pop) begin
      d0_d = d1_q;
      c0_d = c1_q;
    end
    // the new word lands right behind whatever survives the pop
    if (push) begin
      if (cnt_pop == 2'd0) begin
        d0_d = push_data;
        c0_d = push_ch;
      end else begin
        d1_d = push_data;
        c1_d = push_ch;
      end
    end
    cnt_d   = cnt_pop + 2'(push);
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      d0_q    <= '0;
      d1_q    <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head_data  = d0_q;
  assign head_ch    = c0_q;
  assign head_valid = valid_q;
  assign occ        = cnt_q;

endmodule

// File: rtl/fifo_ms_drain_arb.sv
// fifo_ms_drain_arb: drains a dual-channel FIFO into a 2-entry skid.
// Define FIFO_MS_DRAIN_CNT_EN to add per-channel transfer counters.
module fifo_ms_drain_arb
  import fifo_ms_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [NCH-1:0] empty,
  input  logic [DW-1:0]  dataout,
  output logic [NCH-1:0] rd,
  output logic [DW-1:0]  out_data,
  output logic           out_ch,
  output logic           out_valid,
  input  logic           out_ready
`ifdef FIFO_MS_DRAIN_CNT_EN
  ,
  output logic [CNT_W-1:0] drained_cnt0,
  output logic [CNT_W-1:0] drained_cnt1
`endif
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST);

  arb_state_e     state_q, state_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic           inflight_q, inflight_d;
  logic           inflight_ch_q, inflight_ch_d;
  logic [NCH-1:0] last_rd_q, last_rd_d;
  logic [NCH-1:0] rd_c;
  logic [1:0]     occ, load;
  logic           room, sw;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty[0])      state_d = GNT0;
        else if (!empty[1]) state_d = GNT1;
      end
      GNT0: begin
        if (&empty) state_d = IDLE;
        else if (!empty[1] && (empty[0] || burst_q == BMAX))
          state_d = GNT1;
      end
      GNT1: begin
        if (&empty) state_d = IDLE;
        else if (!empty[0] && (empty[1] || burst_q == BMAX))
          state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sw   = (state_d != state_q);
  assign load = occ + {1'b0, inflight_q};
  assign room = (load < 2'd2);

  // never re-read a channel whose registered empty has not caught up yet
  always_comb begin
    rd_c = '0;
    if (!sw && room) begin
      unique case (1'b1)
        (state_q == GNT0):
          if (!empty[0] && !last_rd_q[0]) rd_c = 2'b01;
        (state_q == GNT1):
          if (!empty[1] && !last_rd_q[1]) rd_c = 2'b10;
        default: rd_c = '0;
      endcase
    end
  end

  assign rd = rst ? rd_c : '0;

  always_comb begin
    burst_d = burst_q;
    if (sw)
      burst_d = '0;
    else if (|rd_c && burst_q != BMAX)
      burst_d = burst_q + BW'(1);
    inflight_d    = |rd_c;
    inflight_ch_d = rd_c[1];
    last_rd_d     = rd_c;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q       <= IDLE;
      burst_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_ch_q <= 1'b0;
      last_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      inflight_q    <= inflight_d;
      inflight_ch_q <= inflight_ch_d;
      last_rd_q     <= last_rd_d;
    end
  end

  fifo_ms_skid2 #(.DW(DW)) u_skid (
    .ck         (ck),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  (dataout),
    .push_ch    (inflight_ch_q),
    .pop_ready  (out_ready),
    .head_data  (out_data),
    .head_ch    (out_ch),
    .head_valid (out_valid),
    .occ        (occ)
  );

`ifdef FIFO_MS_DRAIN_CNT_EN
  logic             xfer;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    xfer   = out_valid & out_ready;
    cnt0_d = cnt0_q + CNT_W'(xfer & ~out_ch);
    cnt1_d = cnt1_q + CNT_W'(xfer & out_ch);
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign drained_cnt0 = cnt0_q;
  assign drained_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_fifo_ms_drain_arb.sv
// tb_fifo_ms_drain_arb: upstream FIFO model with lagging empty flags,
// scoreboard of words read versus words transferred downstream.
module tb_fifo_ms_drain_arb;
  import fifo_ms_pkg::*;

  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] empty_r = 2'b11;
  logic [7:0] dataout = 8'h00;
  logic       out_ready = 1'b0;
  logic [1:0] rd;
  logic [7:0] out_data;
  logic       out_ch;
  logic       out_valid;
`ifdef FIFO_MS_DRAIN_CNT_EN
  logic [15:0] drained_cnt0, drained_cnt1;
`endif

  fifo_ms_drain_arb #(.DW(8), .BURST(4)) dut (
    .ck        (ck),
    .rst       (rst),
    .empty     (empty_r),
    .dataout   (dataout),
    .rd        (rd),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_MS_DRAIN_CNT_EN
    ,
    .drained_cnt0 (drained_cnt0),
    .drained_cnt1 (drained_cnt1)
`endif
  );

  always #5 ck = ~ck;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] exp_q[$];
  int         rd0_cyc[$];
  logic       ch_log[$];
  int cyc = 0, n_rd = 0, n_both = 0, n_b2b = 0, n_over = 0, n_xfer = 0;
  logic [1:0] rd_prev = 2'b00;
  logic [1:0] e_nxt;
  logic [7:0] w;

  // upstream FIFO: data one cycle after rd, empty flags one cycle late
  always @(posedge ck) begin
    cyc++;
    e_nxt = {q1.size() == 0, q0.size() == 0};
    if (rd === 2'b11) n_both++;
    if ((rd & rd_prev) != 2'b00) n_b2b++;
    rd_prev = rd;
    w = 8'($urandom);
    if (rd[0]) begin
      n_rd++;
      if (q0.size() == 0) n_over++;
      else begin
        w = q0.pop_front();
        exp_q.push_back({1'b0, w});
        rd0_cyc.push_back(cyc);
      end
    end else if (rd[1]) begin
      n_rd++;
      if (q1.size() == 0) n_over++;
      else begin
        w = q1.pop_front();
        exp_q.push_back({1'b1, w});
      end
    end
    dataout <= w;
    empty_r <= e_nxt;
  end

  logic       stall_prev = 1'b0;
  logic [7:0] pd;
  logic       pc;
  logic [8:0] e;

  always @(negedge ck) begin
    if (rst) begin
      if (stall_prev) begin
        check_eq("hold_data", out_data, pd);
        check_eq("hold_ch", out_ch, pc);
        check_eq("hold_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("xfer_unexp", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("xfer_data", out_data, e[7:0]);
          check_eq("xfer_ch", out_ch, e[8]);
        end
        n_xfer++;
        ch_log.push_back(out_ch);
      end
      stall_prev = out_valid && !out_ready;
      pd = out_data;
      pc = out_ch;
    end else stall_prev = 1'b0;
  end

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (n_xfer < n && k < budget) begin
      @(negedge ck);
      k++;
    end
  endtask

  int base, base_rd;
  bit found;
  int t3_ch[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_ch", out_ch, 0);
    @(posedge ck); #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      check_eq("idle_rd", rd, 0);
      check_eq("idle_valid", out_valid, 0);
      check_eq("idle_state", 32'(dut.state_q), 32'(IDLE));
    end

    // single channel, three words
    @(posedge ck); #1;
    out_ready = 1'b1;
    rd0_cyc.delete();
    base = n_xfer;
    q0.push_back(8'h81); q0.push_back(8'h82); q0.push_back(8'h83);
    wait_xfers(base + 3, 60);
    check_eq("t2_xfers", n_xfer - base, 3);
    check_eq("t2_reads", rd0_cyc.size(), 3);
    if (rd0_cyc.size() >= 3) begin
      check_eq("t2_gap1", rd0_cyc[1] - rd0_cyc[0], 2);
      check_eq("t2_gap2", rd0_cyc[2] - rd0_cyc[1], 2);
    end
    repeat (5) @(posedge ck);

    // both channels, burst fairness
    #1;
    ch_log.delete();
    base = n_xfer;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(8'(8'h10 + i));
      q1.push_back(8'(8'h20 + i));
    end
    wait_xfers(base + 12, 300);
    check_eq("t3_xfers", n_xfer - base, 12);
    if (ch_log.size() >= 12)
      for (int i = 0; i < 12; i++)
        check_eq($sformatf("t3_ch%0d", i), ch_log[i], t3_ch[i]);
    repeat (5) @(posedge ck);

    // downstream stalled with five words waiting
    #1;
    out_ready = 1'b0;
    base_rd = n_rd;
    base = n_xfer;
    for (int i = 0; i < 5; i++) q0.push_back(8'(8'h31 + i));
    repeat (20) @(negedge ck);
    check_eq("t4_rd_cnt", n_rd - base_rd, 2);
    check_eq("t4_valid", out_valid, 1);
    check_eq("t4_head", out_data, 8'h31);
    @(posedge ck); #1 out_ready = 1'b1;
    wait_xfers(base + 5, 100);
    check_eq("t4_xfers", n_xfer - base, 5);
    repeat (5) @(posedge ck);

    // reset while a ch1 read is in flight
    #1 q1.push_back(8'hC5);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge ck);
      if (rd[1]) found = 1'b1;
    end
    check_eq("t5_rd1_seen", found, 1);
    @(posedge ck); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge ck);
    check_eq("t5_rst_rd", rd, 0);
    @(negedge ck);
    check_eq("t5_valid0", out_valid, 0);
    @(posedge ck); #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      check_eq("t5_valid", out_valid, 0);
    end

    // 3 ch0 + 2 ch1 transfers after reset
    @(posedge ck); #1;
    base = n_xfer;
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43);
    q1.push_back(8'h51); q1.push_back(8'h52);
    wait_xfers(base + 5, 100);
    check_eq("t6_xfers", n_xfer - base, 5);
    @(posedge ck); #1;
`ifdef FIFO_MS_DRAIN_CNT_EN
    check_eq("t6_cnt0", drained_cnt0, 3);
    check_eq("t6_cnt1", drained_cnt1, 2);
`endif
    repeat (4) @(posedge ck);

    check_eq("rd_both", n_both, 0);
    check_eq("rd_b2b", n_b2b, 0);
    check_eq("over_read", n_over, 0);
    check_eq("sb_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
